// File: rtl/muldiv_pkg.sv
// Shared RV32M definitions: funct3/funct7 codes, sequencer state encoding, operand-sign helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package muldiv_pkg;

    // M-extension funct3 codes
    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    // funct7 that selects the M-extension in the OP opcode space
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Sequencer state encodings
    localparam logic [1:0] STATE_IDLE = 2'b00;
    localparam logic [1:0] STATE_BUSY = 2'b01;
    localparam logic [1:0] STATE_DONE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = STATE_IDLE,
        BUSY = STATE_BUSY,
        DONE = STATE_DONE
    } state_t;

    // Divide/remainder ops all have funct3[2] set.
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

    // rs1 is signed for MUL, MULH, MULHSU, DIV, REM.
    function automatic logic rs1_is_signed(input logic [2:0] f3);
        return (f3 == FUNCT3_MUL) || (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU) ||
               (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    endfunction

    // rs2 is signed for MUL, MULH, DIV, REM.
    function automatic logic rs2_is_signed(input logic [2:0] f3);
        return (f3 == FUNCT3_MUL) || (f3 == FUNCT3_MULH) ||
               (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of shift-add multiply or restoring divide on the {hi,lo} working pair.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when to register the result. Divide path only with MULDIV_DIV_EN.
module muldiv_iter_step #(
    parameter int XLEN = 32
) (
    input  logic            div_mode,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    // Multiply: hi is the partial-product accumulator, lo the multiplier shifting out LSB-first.
    logic [XLEN:0] add_sum;
    assign add_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});

`ifdef MULDIV_DIV_EN
    // Divide: hi is the partial remainder, lo the dividend shifting out MSB-first while
    // quotient bits shift in at the bottom.
    logic [XLEN:0] trial;
    logic [XLEN:0] trial_diff;
    logic          trial_ge;
    assign trial      = {hi, lo[XLEN-1]};
    assign trial_diff = trial - {1'b0, opnd};
    assign trial_ge   = (trial >= {1'b0, opnd});
`else
    logic unused_div_mode;
    assign unused_div_mode = div_mode;
`endif

    // Select the add-shift or trial-subtract update for this iteration.
    always_comb begin
        hi_next = add_sum[XLEN:1];
        lo_next = {add_sum[0], lo[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
        if (div_mode) begin
            hi_next = trial_ge ? trial_diff[XLEN-1:0] : trial[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], trial_ge};
        end
`endif
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer, one bit per cycle; stalls the core through busy.
// Latency: XLEN+1 edges accept-to-rsp_valid for normal ops, 1 edge for special/illegal ops.
// Backpressure: req_ready only in IDLE; result held in DONE until rsp_ready. MULDIV_DIV_EN enables divide.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_illegal,
    output logic            busy
);

    localparam int             CW       = $clog2(XLEN);
    localparam logic [CW-1:0]  CNT_LAST = CW'(XLEN - 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic [XLEN-1:0] opnd_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic            neg_q;
    logic [XLEN-1:0] rsp_data_q;

    // Accept-time operand conditioning
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] rs1_abs;
    logic [XLEN-1:0] rs2_abs;
    logic            accept;
    logic            last_iter;

    // Ops that finish at accept with a fixed result
    logic            shortcut;
    logic [XLEN-1:0] shortcut_data;

    // Iteration datapath
    logic [XLEN-1:0]   hi_nx;
    logic [XLEN-1:0]   lo_nx;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   final_res;

    assign rs1_neg   = rs1_is_signed(funct3) & rs1_data[XLEN-1];
    assign rs2_neg   = rs2_is_signed(funct3) & rs2_data[XLEN-1];
    assign rs1_abs   = rs1_neg ? -rs1_data : rs1_data;
    assign rs2_abs   = rs2_neg ? -rs2_data : rs2_data;
    assign accept    = (state == IDLE) && req_valid;
    assign last_iter = (cnt == CNT_LAST);

`ifdef MULDIV_DIV_EN
    logic rem_neg_q;
    logic div_zero;
    logic div_ovf;

    // Signed overflow only exists for DIV/REM (funct3[0]==0 among divide ops).
    assign div_zero = is_div_op(funct3) && (rs2_data == '0);
    assign div_ovf  = is_div_op(funct3) && !funct3[0] &&
                      (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);

    // Divide-by-zero and signed overflow bypass the iteration loop.
    always_comb begin
        shortcut      = 1'b0;
        shortcut_data = '0;
        if (div_zero) begin
            shortcut      = 1'b1;
            shortcut_data = funct3[1] ? rs1_data : '1;
        end else if (div_ovf) begin
            shortcut      = 1'b1;
            shortcut_data = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    assign rsp_illegal = 1'b0;
`else
    logic rsp_illegal_q;

    // Without divide hardware, every divide op is answered at once as illegal.
    always_comb begin
        shortcut      = is_div_op(funct3);
        shortcut_data = '0;
    end

    assign rsp_illegal = rsp_illegal_q;
`endif

    muldiv_iter_step #(
        .XLEN (XLEN)
    ) u_step (
        .div_mode (op_q[2]),
        .hi       (hi_q),
        .lo       (lo_q),
        .opnd     (opnd_q),
        .hi_next  (hi_nx),
        .lo_next  (lo_nx)
    );

    assign prod     = {hi_nx, lo_nx};
    assign prod_fix = neg_q ? -prod : prod;

    // Sign-corrected result of the final iteration, selected by op.
    always_comb begin
        final_res = '0;
        case (op_q)
            FUNCT3_MUL:                               final_res = prod_fix[XLEN-1:0];
            FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
            FUNCT3_DIV, FUNCT3_DIVU:                  final_res = neg_q ? -lo_nx : lo_nx;
            FUNCT3_REM, FUNCT3_REMU:                  final_res = rem_neg_q ? -hi_nx : hi_nx;
`endif
            default:                                  final_res = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded handshake/stall outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_next = shortcut ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture at accept, one iteration per BUSY cycle, result capture on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            op_q       <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_q      <= 1'b0;
            rsp_data_q <= '0;
`ifdef MULDIV_DIV_EN
            rem_neg_q  <= 1'b0;
`else
            rsp_illegal_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_q  <= funct3;
                cnt   <= '0;
                hi_q  <= '0;
                neg_q <= rs1_neg ^ rs2_neg;
                if (is_div_op(funct3)) begin
                    lo_q   <= rs1_abs;
                    opnd_q <= rs2_abs;
                end else begin
                    lo_q   <= rs2_abs;
                    opnd_q <= rs1_abs;
                end
`ifdef MULDIV_DIV_EN
                rem_neg_q <= rs1_neg;
`else
                rsp_illegal_q <= shortcut;
`endif
                if (shortcut) begin
                    rsp_data_q <= shortcut_data;
                end
            end else if (state == BUSY) begin
                hi_q <= hi_nx;
                lo_q <= lo_nx;
                cnt  <= cnt + 1'b1;
                if (last_iter) begin
                    rsp_data_q <= final_res;
                end
            end
        end
    end

    assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed results, latency, handshake and reset behaviour.
// Latency: counts edges from the accept edge (inclusive) to the edge raising rsp_valid.
// Backpressure: exercises rsp_ready held low in DONE; divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_illegal;
    logic        busy;

    int errors = 0;
    int checks = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .funct3      (funct3),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_illegal (rsp_illegal),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure latency, check result, optionally stall rsp_ready, check return to IDLE.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_d, input logic exp_ill, input int exp_lat,
                          input int hold, input string tag);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        chk({tag, "/req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        funct3    = f3;
        rs1_data  = a;
        rs2_data  = b;
        rsp_ready = (hold == 0);
        @(posedge clk);
        lat     = 1;
        busy_ok = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        funct3    = 3'b000;
        rs1_data  = 32'hDEADBEEF;
        rs2_data  = 32'h0BADF00D;
        while (!rsp_valid && lat < 60) begin
            busy_ok = busy_ok & busy & ~req_ready;
            @(negedge clk);
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/data"}, rsp_data, exp_d);
        chk({tag, "/illegal"}, 32'(rsp_illegal), 32'(exp_ill));
        chk({tag, "/busy_throughout"}, 32'(busy_ok & busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "/hold_data"}, rsp_data, exp_d);
            chk({tag, "/hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, "/after_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "/after_busy"}, 32'(busy), 32'd0);
        chk({tag, "/after_req_ready"}, 32'(req_ready), 32'd1);
        rsp_ready = 1'b0;
    endtask

    // Divide op: real result with divide hardware, illegal/zero otherwise.
    task automatic run_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_d, input int lat_en, input string tag);
        run_op(f3, a, b, DIV_EN ? exp_d : 32'h0, !DIV_EN, DIV_EN ? lat_en : 1, 0, tag);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        req_valid = 1'b0;
        funct3    = 3'b000;
        rs1_data  = 32'h0;
        rs2_data  = 32'h0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset/req_ready", 32'(req_ready), 32'd1);
        chk("reset/rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset/rsp_data", rsp_data, 32'h0);
        chk("reset/rsp_illegal", 32'(rsp_illegal), 32'd0);
        chk("reset/busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Multiply
        run_op(FUNCT3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33, 0, "mul_7_m3");
        run_op(FUNCT3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33, 0, "mulhu_max");
        run_op(FUNCT3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33, 0, "mulh_m1");
        run_op(FUNCT3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 33, 0, "mulhsu_m1_2");
        run_op(FUNCT3_MUL,    32'h00012345, 32'h00010000, 32'h23450000, 1'b0, 33, 0, "mul_low_wrap");

        // Divide / remainder
        run_div(FUNCT3_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_m7_2");
        run_div(FUNCT3_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_m7_2");
        run_div(FUNCT3_DIVU, 32'd100,      32'd7,        32'd14,       33, "divu_100_7");
        run_div(FUNCT3_REMU, 32'd100,      32'd7,        32'd2,        33, "remu_100_7");
        run_div(FUNCT3_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "divu_by0");
        run_div(FUNCT3_REM,  32'd5,        32'd0,        32'd5,        1,  "rem_by0");
        run_div(FUNCT3_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf");
        run_div(FUNCT3_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "rem_ovf");

        // Consumer stalls 5 cycles in DONE
        run_op(FUNCT3_MULH, 32'h12345678, 32'h00000010, 32'h00000001, 1'b0, 33, 5, "mulh_hold");

        // Reset in the middle of an iterating op
        @(negedge clk);
        req_valid = 1'b1;
        funct3    = DIV_EN ? FUNCT3_DIV : FUNCT3_MULHU;
        rs1_data  = 32'hFFFFFF00;
        rs2_data  = 32'd3;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst/busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst/req_ready", 32'(req_ready), 32'd1);
        chk("midrst/rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst/rsp_data", rsp_data, 32'h0);
        chk("midrst/rsp_illegal", 32'(rsp_illegal), 32'd0);
        chk("midrst/busy", 32'(busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        chk("midrst/no_response", 32'(seen), 32'd0);
        rsp_ready = 1'b0;
        run_op(FUNCT3_MUL, 32'd3, 32'd4, 32'd12, 1'b0, 33, 0, "mul_3_4_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RV32M multiply/divide operations that the single-cycle ALU cannot complete in one cycle. It accepts one request from the decode/execute stage over a valid/ready handshake and runs an iterative shift-add multiply or restoring divide, one bit per cycle. It returns the 32-bit result over a second handshake and holds `busy` high so the PC/control logic can stall the core meanwhile.

## Interface
- `XLEN`, 32: operand/result width; iteration count equals `XLEN`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: sequencer can accept; high only in IDLE.
- `funct3` input 3: M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data` input XLEN: multiplicand/dividend.
- `rs2_data` input XLEN: multiplier/divisor.
- `rsp_valid` output 1: result valid; high only in DONE.
- `rsp_ready` input 1: consumer takes result.
- `rsp_data` output XLEN: result.
- `rsp_illegal` output 1: op not supported in this build; qualified by `rsp_valid`.
- `busy` output 1: state != IDLE; drives the core stall.

## Operation
- States: IDLE, BUSY, DONE. Encoding 2 bits: IDLE=00, BUSY=01, DONE=10.
- IDLE: `req_ready`=1. On `req_valid`: latch `funct3`; latch absolute operand values (signed per op: MUL/MULH/DIV/REM both signed, MULHSU rs1 signed only, others unsigned); record result sign; clear accumulator; counter=0; go to BUSY.
- Special cases go IDLE->DONE directly with a result fixed at accept:
  - divide by zero: DIV/DIVU quotient = all ones; REM/REMU = rs1.
  - signed overflow (rs1=0x80000000, rs2=-1): DIV = 0x80000000; REM = 0.
- BUSY: one iteration per cycle. Multiply is shift-add producing a 2·XLEN product. Divide is restoring, producing quotient and remainder. Counter increments 0..XLEN-1.
- Final BUSY cycle (counter = XLEN-1) performs the last iteration and the sign correction into `rsp_data`, then goes to DONE:
  - two's-complement negate of product/quotient if signs differ.
  - remainder takes the dividend's sign.
- Result selection:
  - MUL: low half of the product.
  - MULH/MULHSU/MULHU: high half.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE: `rsp_valid`=1; `rsp_data`/`rsp_illegal` stable until `rsp_ready`. On `rsp_ready`, go to IDLE. A new request is not accepted in the same cycle; earliest next accept is one cycle later.
- `req_valid` while not IDLE is ignored (`req_ready`=0); the requester holds its inputs.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_illegal`=0, `busy`=0, counter=0.
- `rst` mid-operation: at the next edge, return to IDLE with all outputs at reset values. The pending result is discarded and no response is issued.
- Latency, accept edge to `rsp_valid` high:
  - normal ops: XLEN+1 cycles (33 for XLEN=32).
  - special cases and illegal ops: 1 cycle.
- `busy` rises the cycle after accept and falls the cycle after the `rsp_valid && rsp_ready` edge.
- All outputs are registered or decoded from state only; no combinational path from `req_valid`/`rsp_ready` to outputs except via state.

## Configuration
- `MULDIV_DIV_EN` defined: full operation set.
- `MULDIV_DIV_EN` undefined:
  - divide hardware is not built.
  - funct3 100–111 are accepted and go directly to DONE with `rsp_data`=0 and `rsp_illegal`=1 (1-cycle latency).
  - multiply ops are unchanged.
  - with the macro defined, `rsp_illegal` is tied to 0.

## Structure
- Shared defines file (alongside the existing ALU op and funct codes): `FUNCT3_MUL`…`FUNCT3_REMU`, `FUNCT7_MULDIV` (0000001), and the state encodings.
- One sub-module, `muldiv_iter_step`: purely combinational single-iteration step (add-shift or trial-subtract). The sequencer keeps the state machine, counter, operand/sign registers and result mux.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD, `rsp_ready`=1 -> `rsp_valid` 33 cycles after accept, `rsp_data`=0xFFFFFFEB, `busy` high throughout.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULH of the same operands -> 0x00000000. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM of the same -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF after 1 cycle. REM 5/0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same -> 0.
- `rsp_ready` held low 5 cycles in DONE -> `rsp_valid` and `rsp_data` stable, `req_ready`=0. Then `rsp_ready`=1 -> IDLE next cycle.
- Assert `rst` at iteration 10 of a DIV -> all outputs at reset values next cycle, no `rsp_valid`. Next MUL 3×4 -> 12. Without `MULDIV_DIV_EN`: DIV -> `rsp_illegal`=1, `rsp_data`=0 after 1 cycle.
